// File: rtl/gpio_in_pkg.sv
// Shared constants and helpers for the GPIO input debouncer.
package gpio_in_pkg;

   localparam int GPIO_IN_WIDTH           = 12;
   localparam int GPIO_IN_CLK_HZ          = 100_000_000;
   localparam int GPIO_IN_DEBOUNCE_CYCLES = GPIO_IN_CLK_HZ / 100;

   // A 1-cycle window still needs a 1-bit counter, hence the floor of 1.
   function automatic int cntWidth(input int cycles);
      return (cycles > 1) ? $clog2(cycles) : 1;
   endfunction

endpackage

// File: rtl/debounce_chan.sv
// Single-bit debounce channel: two-flop synchronizer, stability counter,
// stable level flop and registered rise/fall pulses.
module debounce_chan
   import gpio_in_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = GPIO_IN_DEBOUNCE_CYCLES,
   parameter logic RESET_BIT       = 1'b0
) (
   input  logic clock,
   input  logic reset_n,
   input  logic pin_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int            CW      = cntWidth(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;

   // The counter only runs while the synchronized pin disagrees with the
   // stable level; it saturates at CNT_MAX because the level flips there.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_MAX) begin
            level_d = sync2_q;
            rise_d  = sync2_q;
            fall_d  = ~sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= RESET_BIT;
         sync2_q <= RESET_BIT;
         cnt_q   <= '0;
         level_q <= RESET_BIT;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync1_q <= pin_i;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule

// File: rtl/gpio_in_debounce.sv
// Debounces WIDTH board switch/button inputs. Define GPIO_IN_DEBOUNCE_EDGE_EN
// to enable rise/fall pulses and the sticky event flag; otherwise they read 0.
module gpio_in_debounce
   import gpio_in_pkg::*;
#(
   parameter int               WIDTH           = GPIO_IN_WIDTH,
   parameter int               DEBOUNCE_CYCLES = GPIO_IN_DEBOUNCE_CYCLES,
   parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] pins_i,
   output logic [WIDTH-1:0] level_o,
   output logic [WIDTH-1:0] rise_o,
   output logic [WIDTH-1:0] fall_o,
   output logic             evt_pending_o,
   input  logic             evt_clr_i
);

   logic [WIDTH-1:0] chanRise;
   logic [WIDTH-1:0] chanFall;

   for (genvar i = 0; i < WIDTH; i++) begin : gChan
      debounce_chan #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_BIT       (RESET_VAL[i])
      ) uChan (
         .clock   (clock),
         .reset_n (reset_n),
         .pin_i   (pins_i[i]),
         .level_o (level_o[i]),
         .rise_o  (chanRise[i]),
         .fall_o  (chanFall[i])
      );
   end

`ifdef GPIO_IN_DEBOUNCE_EDGE_EN
   logic evtPending_q, evtPending_d;

   // A new edge takes priority over a clear arriving in the same cycle.
   always_comb begin
      evtPending_d = evtPending_q;
      if (|{chanRise, chanFall}) begin
         evtPending_d = 1'b1;
      end else if (evt_clr_i) begin
         evtPending_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         evtPending_q <= 1'b0;
      end else begin
         evtPending_q <= evtPending_d;
      end
   end

   assign rise_o        = chanRise;
   assign fall_o        = chanFall;
   assign evt_pending_o = evtPending_q;
`else
   logic unusedEdge;
   assign unusedEdge    = ^{chanRise, chanFall, evt_clr_i};

   assign rise_o        = '0;
   assign fall_o        = '0;
   assign evt_pending_o = 1'b0;
`endif

endmodule
